// File: rtl/frac_clken_gen_if.sv
// Configuration handshake for frac_clken_gen: one increment offer per accept.
interface frac_clken_gen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 24
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (output cfg_valid, cfg_ch, cfg_inc, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_inc, output cfg_ready);
endinterface

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// with glitch-free increment updates and a lock indication.
module frac_clken_ch #(
    parameter int               ACC_W = 24,
    parameter logic [ACC_W-1:0] INIT  = '0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             i_sync,
    input  logic             i_load,
    input  logic [ACC_W-1:0] i_load_inc,
    output logic             o_carry,
    output logic             o_inc_zero,
    output logic             o_ce
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
    assign o_carry    = w_sum[ACC_W];
    assign o_inc_zero = (r_inc == '0);
    assign o_ce       = r_ce;

    // A load on the carry cycle still accumulates with the old increment,
    // so the period in flight completes before the new rate takes over.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_inc <= INIT;
            r_ce  <= 1'b0;
        end else begin
            if (i_sync) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end
            if (i_load) r_inc <= i_load_inc;
        end
    end
endmodule

module frac_clken_gen #(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 24,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = {24'd2343476, 24'd2097152},
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst_n,
    frac_clken_gen_if.slave   cfg,
    input  logic              i_sync,
    output logic [NUM_CH-1:0] o_ce,
    output logic              o_locked
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_COUNTING, ST_LOCKED} lock_st_t;

    logic             r_pend;
    logic [CH_W-1:0]  r_pend_ch;
    logic [ACC_W-1:0] r_pend_inc;
    lock_st_t         r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic              w_acc_hit;
    logic [ACC_W-1:0]  w_load_inc;
    logic [NUM_CH-1:0] w_pend_hit, w_load, w_carry, w_inc_zero;

    assign cfg.cfg_ready = !r_pend;
    // Out-of-range channels are accepted but never reach the pending slot.
    assign w_acc_hit  = cfg.cfg_valid && !r_pend && (32'(cfg.cfg_ch) < 32'(NUM_CH));
    assign w_load_inc = (i_sync && w_acc_hit) ? cfg.cfg_inc : r_pend_inc;
    assign o_locked   = (r_state == ST_LOCKED);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_pend_hit[g] = r_pend && (r_pend_ch == CH_W'(g));
        assign w_load[g] = i_sync
            ? ((w_acc_hit && (cfg.cfg_ch == CH_W'(g))) || w_pend_hit[g])
            : (w_pend_hit[g] && (w_carry[g] || w_inc_zero[g]));

        frac_clken_ch #(
            .ACC_W (ACC_W),
            .INIT  (INIT_INC[g*ACC_W +: ACC_W])
        ) u_ch (
            .refclk     (refclk),
            .rst_n      (rst_n),
            .i_sync     (i_sync),
            .i_load     (w_load[g]),
            .i_load_inc (w_load_inc),
            .o_carry    (w_carry[g]),
            .o_inc_zero (w_inc_zero[g]),
            .o_ce       (o_ce[g])
        );
    end

    // Sync with an accept applies the new increment directly, skipping the slot.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_inc <= '0;
        end else if (w_acc_hit && !i_sync) begin
            r_pend     <= 1'b1;
            r_pend_ch  <= cfg.cfg_ch;
            r_pend_inc <= cfg.cfg_inc;
        end else if (i_sync || (|w_load)) begin
            r_pend     <= 1'b0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UNLOCKED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt holds the number of consecutive stable cycles seen so far.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_UNLOCKED: begin
                w_cnt_nxt = '0;
                if (!r_pend) begin
                    if (LOCK_CYCLES == 1) begin
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_state_nxt = ST_COUNTING;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_COUNTING: begin
                if (!r_pend) begin
                    if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) w_state_nxt = ST_LOCKED;
                    else                                  w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_LOCKED: ;
            default: w_state_nxt = ST_UNLOCKED;
        endcase
        if (i_sync || w_acc_hit) begin
            w_state_nxt = ST_UNLOCKED;
            w_cnt_nxt   = '0;
        end
    end
endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen: per-cycle scoreboard against a rate model
// plus explicit timing checks for period, lock, update, sync and reset behaviour.
module tb_frac_clken_gen;
    localparam int NUM_CH = 2;
    localparam int ACC_W  = 24;
    localparam int LC     = 16;
    localparam logic [NUM_CH*ACC_W-1:0] INIT = {24'd2343476, 24'd2097152};
    localparam longint MOD = 64'd1 << ACC_W;

    typedef struct {
        logic [NUM_CH-1:0] ce;
        logic              locked;
        logic              ready;
    } exp_t;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    logic sync   = 1'b0;
    logic [NUM_CH-1:0] ce;
    logic locked;

    frac_clken_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg ();

    frac_clken_gen #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .INIT_INC(INIT), .LOCK_CYCLES(LC)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .cfg      (cfg.slave),
        .i_sync   (sync),
        .o_ce     (ce),
        .o_locked (locked)
    );

    always #5 refclk = ~refclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t sb[$];

    longint m_acc [NUM_CH];
    longint m_inc [NUM_CH];
    logic [NUM_CH-1:0] m_ce;
    bit     m_pend;
    int     m_pch;
    longint m_pinc;
    int     m_run;
    bit     m_accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0;
            m_inc[i] = longint'(INIT[i*ACC_W +: ACC_W]);
        end
        m_ce = '0; m_pend = 0; m_pch = 0; m_pinc = 0; m_run = 0;
        sb.delete();
    endtask

    task automatic model_step();
        longint sum;
        bit ok, hit, clr;
        ok  = cfg.cfg_valid && !m_pend;
        hit = ok && (int'(cfg.cfg_ch) < NUM_CH);
        m_accepted = ok;
        clr = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = m_acc[i] + m_inc[i];
            if (sync) begin
                m_acc[i] = 0;
                m_ce[i]  = 1'b0;
                if (hit && int'(cfg.cfg_ch) == i) m_inc[i] = longint'(cfg.cfg_inc);
                else if (m_pend && m_pch == i) begin m_inc[i] = m_pinc; clr = 1; end
            end else begin
                m_acc[i] = sum % MOD;
                m_ce[i]  = (sum >= MOD);
                if (m_pend && m_pch == i && (sum >= MOD || m_inc[i] == 0)) begin
                    m_inc[i] = m_pinc; clr = 1;
                end
            end
        end
        if (sync || hit) m_run = 0;
        else if (!m_pend && m_run < LC) m_run++;
        if (clr) m_pend = 0;
        if (hit && !sync) begin
            m_pend = 1; m_pch = int'(cfg.cfg_ch); m_pinc = longint'(cfg.cfg_inc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge refclk);
        model_step();
        e.ce = m_ce; e.locked = (m_run >= LC); e.ready = !m_pend;
        sb.push_back(e);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("sb_ce", ce, e.ce);
        chk("sb_locked", locked, e.locked);
        chk("sb_ready", cfg.cfg_ready, e.ready);
    endtask

    task automatic cfg_write(input int ch, input longint inc, output int stalls);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = ch[0];
        cfg.cfg_inc   = inc[ACC_W-1:0];
        stalls = 0;
        m_accepted = 0;
        while (!m_accepted && stalls < 64) begin
            tick();
            if (!m_accepted) stalls++;
        end
        if (!m_accepted) begin
            failures++;
            $error("FAIL cfg_timeout observed=%0d expected=accept", stalls);
        end
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, n0, n1, t0, s;
        bit found;
        int strobes[$];
        cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_inc = '0;
        repeat (3) @(posedge refclk);
        #1;
        chk("rst_ce", ce, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ready", cfg.cfg_ready, 1);
        @(negedge refclk);
        rst_n = 1'b1; model_reset(); cyc = 0;

        // Reset rates: ch0 every 8th cycle, locked after 16
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t1_ce0_period", ce[0], (cyc % 8 == 0));
            chk("t1_locked", locked, (cyc >= 16));
        end

        // ch1 -> 0 stops its strobes; ch0 untouched
        cfg_write(1, 0, st);
        repeat (60) tick();
        n0 = 0; n1 = 0;
        repeat (96) begin tick(); n0 += int'(ce[0]); n1 += int'(ce[1]); end
        chk("t2_ce1_silent", n1, 0);
        chk("t2_ce0_count", n0, 12);

        // ch0 2^21 -> 2^22 mid-period
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin tick(); found = ce[0]; end
        chk("t3_find_strobe", found, 1);
        t0 = cyc;
        repeat (3) tick();
        cfg_write(0, 64'd1 << 22, st);
        strobes.delete();
        while (cyc < t0 + 40) begin
            tick();
            if (ce[0]) strobes.push_back(cyc);
            if (cyc == t0 + 23) chk("t3_locked_low", locked, 0);
            if (cyc == t0 + 24) chk("t3_locked_back", locked, 1);
        end
        chk("t3_strobe_count", strobes.size(), 9);
        if (strobes.size() >= 2) begin
            chk("t3_old_period", strobes[0] - t0, 8);
            chk("t3_new_period", strobes[1] - strobes[0], 4);
        end

        // Back-to-back writes: second stalls while first pends
        cfg_write(0, 64'd1 << 21, st);
        chk("t4_ready_low", cfg.cfg_ready, 0);
        cfg_write(1, 64'd1 << 20, st);
        chk("t4_stalled", (st > 0), 1);
        repeat (40) tick();
        chk("t4_relocked", locked, 1);

        // Sync pulse: both channels restart phase-aligned
        tick();
        sync = 1'b1; tick(); s = cyc; sync = 1'b0;
        while (cyc < s + 16) begin
            tick();
            chk("t5_ce0", ce[0], (cyc == s + 8 || cyc == s + 16));
            chk("t5_ce1", ce[1], (cyc == s + 16));
            if (cyc == s + 1)  chk("t5_unlocked", locked, 0);
            if (cyc == s + 15) chk("t5_locked_low", locked, 0);
            if (cyc == s + 16) chk("t5_locked_back", locked, 1);
        end

        // Sync held 3 cycles with a same-cycle write to ch0
        cfg.cfg_valid = 1'b1; cfg.cfg_ch = 1'b0; cfg.cfg_inc = 24'd1 << 22; sync = 1'b1;
        tick(); cfg.cfg_valid = 1'b0;
        chk("t5b_ready", cfg.cfg_ready, 1);
        repeat (2) begin tick(); chk("t5b_ce_held", ce, 0); end
        s = cyc; sync = 1'b0;
        while (cyc < s + 8) begin
            tick();
            chk("t5b_ce0", ce[0], (cyc == s + 4 || cyc == s + 8));
        end

        // Reset while a ch1 update is pending
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin tick(); found = ce[1]; end
        chk("t6_find_strobe", found, 1);
        cfg_write(1, 64'd1 << 19, st);
        repeat (2) tick();
        chk("t6_pending", cfg.cfg_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ce", ce, 0);
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_ready", cfg.cfg_ready, 1);
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1; model_reset(); cyc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t6_ce0_period", ce[0], (cyc % 8 == 0));
            chk("t6_locked", locked, (cyc >= 16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
